comp_queue_mc: RTL and testbench
================================

# comp_queue_mc

Multi-channel completion queue that merges completion addresses from NCH crypto engines into one in-order FIFO toward the completion writer. Each accepted entry carries the destination address and the index of the producing channel. Simultaneous requests are arbitrated round-robin, with one acceptance per cycle. This block is the parametrised successor of the two-channel AES/SHA completion queue and adds N channels, channel tagging, occupancy reporting, an almost-full flag and a synchronous flush.

## Interface

Parameters:
- ADDRW, 24: destination address width.
- QDEPTH, 32: FIFO entries. Power of two, ≥ 2.
- NCH, 2: number of producer channels, 2..8.
- AFULL_TH, 28: almost_full asserts when count ≥ AFULL_TH. Range 1..QDEPTH.
- Derived, not overridable: CHW = max(1, $clog2(NCH)); CNTW = $clog2(QDEPTH)+1.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous queue clear.
- valid_in  in  NCH  per-channel completion valid. Bit i belongs to channel i.
- dest_addr_in  in  NCH*ADDRW  flattened addresses. Channel i occupies [i*ADDRW +: ADDRW].
- ready_out  out  NCH  per-channel accept.
- data_out  out  ADDRW  head-entry address.
- chan_out  out  CHW  head-entry channel index.
- valid_out  out  1  head entry valid.
- ready_in  in  1  consumer ready.
- count  out  CNTW  current occupancy, 0..QDEPTH.
- almost_full  out  1  count ≥ AFULL_TH.

## Operation

- Storage: circular buffer of QDEPTH entries, each {chan, addr}. Write and read pointers are $clog2(QDEPTH) bits and wrap naturally. A registered count gives occupancy.
- full = (count == QDEPTH). empty = (count == 0).
- Arbitration (combinational):
  - The rr_ptr register selects the search start.
  - The winner is the first i with valid_in[i]=1, scanning rr_ptr, rr_ptr+1, … mod NCH.
- ready_out[i] = !full && !flush && (winner == i || !valid_in[i]). Losing requesters see ready_out=0 and must hold their request. Idle channels see ready_out = !full && !flush.
- Push: happens when any valid_in is set, !full and !flush. The winner's {i, addr} is written at wr_ptr, wr_ptr increments, and rr_ptr ← (winner+1) mod NCH. rr_ptr does not change on cycles with no push.
- Pop: happens when valid_out && ready_in && !flush. rd_ptr increments.
- count: +1 on push only, −1 on pop only, unchanged on push+pop.
- Push at full is refused, even if a pop happens the same cycle. ready_out reflects the registered full state.
- Flush: at a clock edge with flush=1:
  - wr_ptr, rd_ptr and count go to 0.
  - The queue performs no push and no pop that cycle.
  - rr_ptr keeps its value.
- Reset (rst_n=0 at an edge): pointers, count and rr_ptr go to 0. Storage contents are don't-care. Reset mid-operation discards all pending entries.
- Outputs:
  - valid_out = !empty.
  - {chan_out, data_out} = storage[rd_ptr]. The value is don't-care when valid_out=0.
  - almost_full = (count ≥ AFULL_TH).
- Ordering: output order equals acceptance order across all channels.

## Timing

- Reset values: valid_out=0, count=0, almost_full=0, ready_out = all ones (given flush=0), chan_out and data_out don't-care.
- Accept latency: an entry pushed at edge k makes valid_out=1 and is visible on data_out/chan_out in the cycle after edge k. This latency holds whether or not the queue was empty.
- Pop at edge k: the next entry is presented after edge k. With continuous ready_in=1 and one push per cycle, throughput is one entry per cycle.
- valid_out, data_out and chan_out remain stable while valid_out=1 and ready_in=0.
- count and almost_full are registered-derived and update the cycle after the causing edge.
- Write-pointer wrap (QDEPTH-1 → 0) and read-pointer wrap need no special handling. Order must be preserved across any number of wraps.

## Test plan

- Reset, then idle: valid_out=0, count=0, ready_out='1, almost_full=0.
- Fairness, NCH=3, ready_in=0, all three valid_in held with addrs 0x100/0x200/0x300 for 3 cycles:
  - ready_out one-hot in order ch0, ch1, ch2.
  - After releasing ready_in, the output is (0,0x100), (1,0x200), (2,0x300).
- Fill and almost-full, QDEPTH=32, AFULL_TH=28, ready_in=0, 32 pushes on ch1 (addr = i):
  - almost_full rises the cycle after the 28th push.
  - After the 32nd push: count=32 and ready_out=0.
  - A 33rd push with addr 0xBAD is never emitted.
  - Drain yields 0..31 in order on chan_out=1.
- Full with concurrent pop: at count=32, hold ch0 valid and set ready_in=1 for one cycle.
  - The push is refused that cycle and count becomes 31.
  - The push is accepted the next cycle and count returns to 32.
- Flush and reset mid-operation: with 5 entries queued, pulse flush for 1 cycle.
  - count=0 and valid_out=0 the next cycle.
  - A push on the cycle flush is high is not accepted.
  - Repeat the sequence with rst_n=0 instead of flush; additionally, the winner after reset is ch0.
- Wrap stress: 3 passes of 32 pushes, 10 pops, 6 pushes on random channels, full drain. A scoreboard matches every {chan, addr} in order with zero mismatches.

Source files
------------

// File: rtl/comp_queue_mc.sv
`default_nettype none
// ============================================================================
// comp_queue_mc : round-robin merge of NCH completion streams into one
//                 in-order, channel-tagged FIFO.   Revision 1.0
// ============================================================================
module comp_queue_mc #(
  parameter int ADDRW    = 24,
  parameter int QDEPTH   = 32,
  parameter int NCH      = 2,
  parameter int AFULL_TH = 28,
  localparam int CHW     = (NCH > 2) ? $clog2(NCH) : 1,
  localparam int CNTW    = $clog2(QDEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [NCH-1:0]         valid_in,
  input  logic [NCH*ADDRW-1:0]   dest_addr_in,
  output logic [NCH-1:0]         ready_out,
  output logic [ADDRW-1:0]       data_out,
  output logic [CHW-1:0]         chan_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [CNTW-1:0]        count,
  output logic                   almost_full
);

  localparam int PTRW = $clog2(QDEPTH);
  localparam int ENTW = CHW + ADDRW;

  logic [ENTW-1:0]  mem_q [QDEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [CHW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [CHW-1:0]   winner;
  logic [ADDRW-1:0] win_addr;
  logic             found;
  int               arb_idx;
  logic             any_valid, full, empty, push, pop;

  assign any_valid = |valid_in;
  assign full      = (count_q == CNTW'(QDEPTH));
  assign empty     = (count_q == '0);
  assign push      = any_valid && !full && !flush;
  assign pop       = !empty && ready_in && !flush;

  // Scan rr_ptr, rr_ptr+1, ... (mod NCH); first requester wins.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    arb_idx = 0;
    for (int k = 0; k < NCH; k++) begin
      arb_idx = int'(rr_ptr_q) + k;
      if (arb_idx >= NCH) arb_idx = arb_idx - NCH;
      if (!found && valid_in[CHW'(arb_idx)]) begin
        found  = 1'b1;
        winner = CHW'(arb_idx);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (winner == CHW'(i)) win_addr = dest_addr_in[i*ADDRW +: ADDRW];
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign ready_out[gi] = !full && !flush && ((winner == CHW'(gi)) || !valid_in[gi]);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rr_ptr_d = (winner == CHW'(NCH - 1)) ? '0 : winner + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observable once counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {winner, win_addr};
  end

  assign {chan_out, data_out} = mem_q[rd_ptr_q];
  assign valid_out            = !empty;
  assign count                = count_q;
  assign almost_full          = (count_q >= CNTW'(AFULL_TH));

endmodule
`default_nettype wire

// File: tb/tb_comp_queue_mc.sv
`default_nettype none
// tb_comp_queue_mc : randomized scoreboard bench for comp_queue_mc (NCH=3, QDEPTH=32).
module tb_comp_queue_mc;

  localparam int ADDRW    = 24;
  localparam int QDEPTH   = 32;
  localparam int NCH      = 3;
  localparam int AFULL_TH = 28;
  localparam int CHW      = 2;
  localparam int CNTW     = 6;
  localparam int ENTW     = CHW + ADDRW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic                 ready_in = 1'b0;
  logic [NCH-1:0]       valid_in = '0;
  logic [NCH*ADDRW-1:0] dest_addr_in = '0;
  logic [NCH-1:0]       ready_out;
  logic [ADDRW-1:0]     data_out;
  logic [CHW-1:0]       chan_out;
  logic                 valid_out;
  logic [CNTW-1:0]      count;
  logic                 almost_full;

  comp_queue_mc #(
    .ADDRW(ADDRW), .QDEPTH(QDEPTH), .NCH(NCH), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .valid_in(valid_in), .dest_addr_in(dest_addr_in), .ready_out(ready_out),
    .data_out(data_out), .chan_out(chan_out), .valid_out(valid_out),
    .ready_in(ready_in), .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  logic [ENTW-1:0] sb[$];
  logic [ENTW-1:0] popped[$];
  logic [ENTW-1:0] head_exp;
  int  checks = 0;
  int  failures = 0;
  int  pre_count = 0;
  int  rr = 0;
  int  accepted = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: occupancy flags against the model, head entry against scoreboard.
  always @(negedge clk) begin
    #1;
    pre_count = sb.size();
    if (mon_en) begin
      chk("count", 32'(count), pre_count);
      chk("valid_out", 32'(valid_out), 32'(pre_count != 0));
      chk("almost_full", 32'(almost_full), 32'(pre_count >= AFULL_TH));
      if (valid_out && ready_in && !flush && rst_n) begin
        popped.push_back({chan_out, data_out});
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_on_empty: actual entry=0x%0h required no entry", {chan_out, data_out});
        end else begin
          head_exp = sb.pop_front();
          chk("head_entry", 32'({chan_out, data_out}), 32'(head_exp));
        end
      end
    end
  end

  task automatic set_addr(input int c, input logic [ADDRW-1:0] a);
    dest_addr_in[c*ADDRW +: ADDRW] = a;
  endtask

  // Reference: round-robin pick from the last winner, accept if not full and no flush.
  task automatic eval_cycle();
    int win;
    int c;
    bit full;
    logic [NCH-1:0] exp_rdy;
    if (!rst_n) begin
      sb.delete();
      rr = 0;
      return;
    end
    full = (pre_count == QDEPTH);
    win = -1;
    for (int k = 0; k < NCH; k++) begin
      c = (rr + k) % NCH;
      if (win < 0 && valid_in[c]) win = c;
    end
    for (int i = 0; i < NCH; i++) exp_rdy[i] = !full && !flush && (win == i || !valid_in[i]);
    if (mon_en) chk("ready_out", 32'(ready_out), 32'(exp_rdy));
    if (flush) sb.delete();
    else if (win >= 0 && !full) begin
      sb.push_back({CHW'(win), dest_addr_in[win*ADDRW +: ADDRW]});
      rr = (win + 1) % NCH;
      accepted++;
    end
  endtask

  task automatic cyc();
    #2;
    eval_cycle();
    @(negedge clk);
  endtask

  task automatic drain();
    valid_in = '0;
    ready_in = 1'b1;
    for (int n = 0; n < 4*QDEPTH && sb.size() != 0; n++) cyc();
    chk("drain_left", sb.size(), 0);
    ready_in = 1'b0;
    cyc();
  endtask

  task automatic push_n(input int n);
    int a0;
    a0 = accepted;
    ready_in = 1'b0;
    for (int t = 0; t < 8*n && accepted - a0 < n; t++) begin
      valid_in = NCH'($urandom_range(7, 1));
      for (int c = 0; c < NCH; c++) set_addr(c, ADDRW'($urandom));
      cyc();
    end
    valid_in = '0;
    chk("push_progress", accepted - a0, n);
  endtask

  task automatic pop_n(input int n);
    valid_in = '0;
    ready_in = 1'b1;
    repeat (n) cyc();
    ready_in = 1'b0;
  endtask

  task automatic queue_five();
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 3'b001 << $urandom_range(2, 0);
      for (int c = 0; c < NCH; c++) set_addr(c, ADDRW'($urandom));
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) cyc();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset / idle state
    #1;
    chk("reset_valid_out", 32'(valid_out), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_ready_out", 32'(ready_out), 32'h7);
    chk("reset_almost_full", 32'(almost_full), 0);
    cyc();

    // Fairness: all three requesting, expect one-hot ready in order ch0, ch1, ch2
    set_addr(0, 24'h100); set_addr(1, 24'h200); set_addr(2, 24'h300);
    valid_in = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fair_ready", 32'(ready_out), 32'(1) << i);
      cyc();
    end
    popped.delete();
    drain();
    chk("fair_popped", popped.size(), 3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      chk("fair_order", 32'(popped[i]), 32'({CHW'(i), ADDRW'((i + 1) * 'h100)}));

    // Fill on ch1 with almost-full threshold, then refused 33rd push
    popped.delete();
    for (int i = 0; i < QDEPTH; i++) begin
      valid_in = 3'b010;
      set_addr(1, ADDRW'(i));
      #1;
      if (i == AFULL_TH - 1) chk("afull_before", 32'(almost_full), 0);
      if (i == AFULL_TH)     chk("afull_after", 32'(almost_full), 1);
      cyc();
    end
    set_addr(1, 24'hBAD);
    #1;
    chk("full_count", 32'(count), 32);
    chk("full_ready", 32'(ready_out), 0);
    cyc();

    // Full with concurrent pop: push refused, then accepted next cycle
    valid_in = 3'b001;
    set_addr(0, 24'h55);
    ready_in = 1'b1;
    cyc();
    ready_in = 1'b0;
    #1;
    chk("full_pop_count", 32'(count), 31);
    cyc();
    valid_in = '0;
    #1;
    chk("refill_count", 32'(count), 32);
    cyc();
    drain();
    chk("fill_popped", popped.size(), 33);
    for (int i = 0; i < QDEPTH && i < popped.size(); i++)
      chk("fill_order", 32'(popped[i]), 32'({2'd1, ADDRW'(i)}));
    if (popped.size() == 33) chk("fill_last", 32'(popped[32]), 32'({2'd0, 24'h55}));

    // Flush mid-operation with a simultaneous push attempt
    queue_five();
    valid_in = 3'b111;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    valid_in = '0;
    #1;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid_out", 32'(valid_out), 0);
    cyc();

    // Reset mid-operation; arbitration restarts at ch0
    queue_five();
    valid_in = 3'b010;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    valid_in = 3'b111;
    set_addr(0, 24'hA0); set_addr(1, 24'hA1); set_addr(2, 24'hA2);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_winner", 32'(ready_out), 32'h1);
    cyc();
    drain();

    // Wrap stress on random channels and addresses
    for (int p = 0; p < 3; p++) begin
      push_n(QDEPTH);
      pop_n(10);
      push_n(6);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
